// File: rtl/mem_sram_ctrl_pkg.sv
// Shared constants for the MEM-stage SRAM controller: widths, defaults and FSM state codes.
package mem_sram_ctrl_pkg;
  localparam int DATA_W          = 32;
  localparam int SRAM_AW         = 18;
  localparam int SRAM_DW         = 16;
  localparam int BASE_ADDR_DEF   = 1024;
  localparam int DEPTH_WORDS_DEF = 65536;
  localparam int WAIT_CYCLES_DEF = 3;
  localparam int WCNT_W          = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LO   = 2'd1;
  localparam logic [1:0] ST_HI   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/mem_sram_ctrl_if.sv
// EXE->MEM request/response signals plus the external asynchronous SRAM pins.
interface mem_sram_ctrl_if;
  import mem_sram_ctrl_pkg::*;

  // Handshake: a request (mem_r_en | mem_w_en) is held by the pipeline while freeze=1;
  // ready pulses for one cycle with freeze=0, and the pipeline advances on that edge.
  logic                mem_r_en;
  logic                mem_w_en;
  logic [DATA_W-1:0]   address;
  logic [DATA_W-1:0]   wr_data;
  logic [DATA_W-1:0]   rd_data;
  logic                ready;
  logic                freeze;
  logic [SRAM_AW-1:0]  sram_addr;
  logic [SRAM_DW-1:0]  sram_dq_out;
  logic [SRAM_DW-1:0]  sram_dq_in;
  logic                sram_dq_oe;
  logic                sram_we_n;
  logic                sram_oe_n;

  modport slave (
    input  mem_r_en, mem_w_en, address, wr_data, sram_dq_in,
    output rd_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );

  modport master (
    output mem_r_en, mem_w_en, address, wr_data, sram_dq_in,
    input  rd_data, ready, freeze, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
  );
endinterface

// File: rtl/mem_sram_ctrl_wait_counter.sv
// Loadable down-counter with zero flag; times one SRAM half-word phase.
module mem_sram_ctrl_wait_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_count,
  output logic             o_zero
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);
endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: each 32-bit load/store becomes two wait-stated 16-bit SRAM accesses.
module mem_sram_ctrl
  import mem_sram_ctrl_pkg::*;
#(
  parameter int BIT_NUMBER  = 32,
  parameter int BASE_ADDR   = BASE_ADDR_DEF,
  parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  mem_sram_ctrl_if.slave      bus,
  output logic [1:0]          o_dbg_state
);
  localparam logic [DATA_W-1:0] BASE   = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] SPAN   = DATA_W'(DEPTH_WORDS) << 2;
  localparam logic [WCNT_W-1:0] RELOAD = WCNT_W'(WAIT_CYCLES - 1);

  logic [1:0]            r_state;
  logic [SRAM_AW-2:0]    r_word;
  logic                  r_is_wr;
  logic [BIT_NUMBER-1:0] r_wdata;
  logic [DATA_W-1:0]     r_rd_data;
  logic [SRAM_AW-1:0]    r_sram_addr;
  logic [SRAM_DW-1:0]    r_dq_out;
  logic                  r_dq_oe;
  logic                  r_we_n;
  logic                  r_oe_n;

  logic                  w_req;
  logic [DATA_W-1:0]     w_off;
  logic                  w_in_range;
  logic [SRAM_AW-2:0]    w_word;
  logic [WCNT_W-1:0]     w_count;
  logic                  w_cnt_zero;
  logic                  w_cnt_one;
  logic                  w_cnt_load;
  logic                  w_cnt_dec;

  assign w_req      = bus.mem_r_en | bus.mem_w_en;
  assign w_off      = bus.address - BASE;
  // Comparing the byte offset against DEPTH*4 is the same as comparing the word index.
  assign w_in_range = (bus.address >= BASE) && (w_off < SPAN);
  assign w_word     = w_off[SRAM_AW:2];
  assign w_cnt_one  = (w_count == WCNT_W'(1));
  assign w_cnt_load = ((r_state == ST_IDLE) && w_req && w_in_range) ||
                      ((r_state == ST_LO) && w_cnt_zero);
  assign w_cnt_dec  = (r_state == ST_LO) || (r_state == ST_HI);

  mem_sram_ctrl_wait_counter #(.CNT_W(WCNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (RELOAD),
    .i_dec      (w_cnt_dec),
    .o_count    (w_count),
    .o_zero     (w_cnt_zero)
  );

  // SRAM pins are registered and set on the edge entering each cycle, so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_word      <= '0;
      r_is_wr     <= 1'b0;
      r_wdata     <= '0;
      r_rd_data   <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_in_range) begin
              r_word      <= w_word;
              r_is_wr     <= bus.mem_w_en;
              r_wdata     <= bus.wr_data;
              r_sram_addr <= {w_word, 1'b0};
              r_dq_out    <= bus.wr_data[15:0];
              r_dq_oe     <= bus.mem_w_en;
              r_we_n      <= ~bus.mem_w_en;
              r_oe_n      <= bus.mem_w_en;
              r_state     <= ST_LO;
            end else begin
              r_rd_data   <= '0;
              r_state     <= ST_DONE;
            end
          end
        end
        ST_LO: begin
          if (w_cnt_zero) begin
            if (!r_is_wr) r_rd_data[15:0] <= bus.sram_dq_in;
            r_sram_addr <= {r_word, 1'b1};
            r_dq_out    <= r_wdata[31:16];
            r_we_n      <= ~r_is_wr;
            r_state     <= ST_HI;
          end else if (w_cnt_one) begin
            r_we_n      <= 1'b1;
          end
        end
        ST_HI: begin
          if (w_cnt_zero) begin
            if (!r_is_wr) r_rd_data[31:16] <= bus.sram_dq_in;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_state     <= ST_DONE;
          end else if (w_cnt_one) begin
            r_we_n      <= 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.freeze      = ((r_state == ST_IDLE) && w_req) || (r_state == ST_LO) || (r_state == ST_HI);
  assign bus.ready       = (r_state == ST_DONE);
  assign bus.rd_data     = r_rd_data;
  assign bus.sram_addr   = r_sram_addr;
  assign bus.sram_dq_out = r_dq_out;
  assign bus.sram_dq_oe  = r_dq_oe;
  assign bus.sram_we_n   = r_we_n;
  assign bus.sram_oe_n   = r_oe_n;
  assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Randomized bench for mem_sram_ctrl: SRAM model plus word-level reference memory and timing rules.
module tb_mem_sram_ctrl;
  import mem_sram_ctrl_pkg::*;

  localparam int W          = 3;
  localparam int BASE       = 1024;
  localparam int DEPTH      = 65536;
  localparam int HALF_WORDS = 262144;
  localparam int MAX_CYC    = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  mem_sram_ctrl_if bus();

  mem_sram_ctrl #(
    .BIT_NUMBER  (32),
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH),
    .WAIT_CYCLES (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rd;
  logic [31:0] ref_mem [int];
  logic [15:0] sram_mem [0:HALF_WORDS-1];

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] ref_word(input int wd);
    if (ref_mem.exists(wd)) return ref_mem[wd];
    return {init_val(2 * wd + 1), init_val(2 * wd)};
  endfunction

  // Asynchronous SRAM model: reads follow oe_n, writes land on clock edges while we_n is low.
  assign bus.sram_dq_in = bus.sram_oe_n ? 16'hA5A5 : sram_mem[bus.sram_addr];

  initial begin
    for (int i = 0; i < HALF_WORDS; i++) sram_mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (!bus.sram_we_n && bus.sram_dq_oe) sram_mem[bus.sram_addr] = bus.sram_dq_out;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Applies one instruction just after a clock edge; cycle 0 is the IDLE cycle that sees it.
  task automatic do_op(input logic r, input logic w, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] off;
    logic        in_rng;
    int          wd, exp_lat, done_k, ph;
    int          frz, we0, we1, dqc, oec, bad;
    off     = addr - 32'(BASE);
    in_rng  = (addr >= 32'(BASE)) && ((off >> 2) < 32'(DEPTH));
    wd      = in_rng ? int'(off >> 2) : 0;
    exp_lat = in_rng ? 2 * W + 1 : 1;
    frz = 0; we0 = 0; we1 = 0; dqc = 0; oec = 0; bad = 0; done_k = -1;
    bus.mem_r_en = r;
    bus.mem_w_en = w;
    bus.address  = addr;
    bus.wr_data  = data;
    for (int k = 0; k < MAX_CYC; k++) begin
      @(negedge clk);
      if (bus.freeze) frz++;
      ph = 0;
      if (in_rng && k >= 1 && k <= W) ph = 1;
      if (in_rng && k > W && k <= 2 * W) ph = 2;
      if (!bus.sram_we_n) begin
        if (ph == 1) we0++;
        else if (ph == 2) we1++;
        else bad++;
      end
      if (bus.sram_dq_oe) begin
        dqc++;
        if (ph == 0 || bus.sram_dq_out !== (ph == 1 ? data[15:0] : data[31:16])) bad++;
      end
      if (!bus.sram_oe_n) begin
        oec++;
        if (ph == 0) bad++;
      end
      if ((!bus.sram_oe_n || bus.sram_dq_oe) && ph != 0 && bus.sram_addr !== 18'(2 * wd + ph - 1)) bad++;
      if (in_rng && (k == W || k == 2 * W) && !bus.sram_we_n) bad++;
      if (bus.ready) begin
        done_k = k;
        break;
      end
    end
    if (!in_rng) exp_rd = 32'h0;
    else if (w) ref_mem[wd] = data;
    else exp_rd = ref_word(wd);
    check("latency", 32'(done_k), 32'(exp_lat));
    check("rd_data", bus.rd_data, exp_rd);
    check("freeze_cycles", 32'(frz), 32'(exp_lat));
    check("we_lo_phase0", 32'(we0), (in_rng && w) ? 32'(W - 1) : 32'h0);
    check("we_lo_phase1", 32'(we1), (in_rng && w) ? 32'(W - 1) : 32'h0);
    check("dq_oe_cycles", 32'(dqc), (in_rng && w) ? 32'(2 * W) : 32'h0);
    check("oe_lo_cycles", 32'(oec), (in_rng && !w) ? 32'(2 * W) : 32'h0);
    check("bus_errors", 32'(bad), 32'h0);
    if (in_rng && w) begin
      check("sram_lo", 32'(sram_mem[2 * wd]), 32'(data[15:0]));
      check("sram_hi", 32'(sram_mem[2 * wd + 1]), 32'(data[31:16]));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_flags", 32'({bus.freeze, bus.ready, bus.sram_we_n, bus.sram_oe_n, bus.sram_dq_oe}), 32'(5'b00110));
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 32'(BASE) + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      6:       return 32'(BASE) + 32'(DEPTH - 1) * 4 + 32'($urandom_range(0, 3));
      7:       return 32'(BASE) + 32'(DEPTH) * 4 + 32'($urandom_range(0, 3));
      8:       return 32'($urandom_range(0, BASE - 1));
      default: return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    endcase
  endfunction

  initial begin
    int sel;
    rst          = 1'b1;
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b0;
    bus.address  = '0;
    bus.wr_data  = '0;
    exp_rd       = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_rd_data", bus.rd_data, 32'h0);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_sram_addr", 32'(bus.sram_addr), 32'h0);
    check("rst_dq_out", 32'(bus.sram_dq_out), 32'h0);
    check("rst_strobes", 32'({bus.sram_dq_oe, bus.sram_we_n, bus.sram_oe_n}), 32'(3'b011));
    check("rst_freeze", 32'(bus.freeze), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(posedge clk);
    #1;

    do_op(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, 32'd1032, 32'h0);
    check("load_back", bus.rd_data, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, 32'd512, 32'h0);
    idle(2);
    do_op(1'b1, 1'b1, 32'd1024, 32'h1234_5678);
    check("both_en_hw0", 32'(sram_mem[0]), 32'h5678);
    check("both_en_hw1", 32'(sram_mem[1]), 32'h1234);
    do_op(1'b1, 1'b0, 32'(BASE) + 32'(DEPTH - 1) * 4, 32'h0);
    do_op(1'b1, 1'b0, 32'(BASE) + 32'(DEPTH) * 4, 32'h0);
    do_op(1'b1, 1'b0, 32'd1032, 32'h0);
    do_op(1'b0, 1'b1, 32'(BASE - 4), 32'h1111_2222);
    do_op(1'b1, 1'b0, 32'd1035, 32'h0);

    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 2));
      do_op(sel != 1, sel != 0, rand_addr(), $urandom);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end

    // Reset in the second HI cycle of a store to a word that is never read afterwards.
    bus.mem_r_en = 1'b0;
    bus.mem_w_en = 1'b1;
    bus.address  = 32'(BASE + 800);
    bus.wr_data  = 32'hCAFE_F00D;
    for (int k = 0; k <= W + 2; k++) @(negedge clk);
    check("pre_rst_we_n", 32'(bus.sram_we_n), 32'h0);
    check("pre_rst_addr", 32'(bus.sram_addr), 32'd401);
    rst          = 1'b1;
    bus.mem_w_en = 1'b0;
    #1;
    check("mid_rst_strobes", 32'({bus.sram_we_n, bus.sram_dq_oe, bus.sram_oe_n}), 32'(3'b101));
    check("mid_rst_freeze", 32'(bus.freeze), 32'h0);
    check("mid_rst_rd_data", bus.rd_data, 32'h0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_ready", 32'(bus.ready), 32'h0);
    end
    rst    = 1'b0;
    exp_rd = 32'h0;
    @(posedge clk);
    #1;
    idle(2);
    do_op(1'b1, 1'b0, 32'd1032, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
